tl_txn_tracker: RTL and testbench

TL_TXN_TRACKER -- requirements
Module: tl_txn_tracker

---
 rtl/tl_txn_tracker_pkg.sv | 55 +++++
 rtl/tl_tracker_slot.sv | 110 +++++++++++
 rtl/tl_txn_tracker.sv | 164 ++++++++++++++++
 tb/tb_tl_txn_tracker.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_txn_tracker_pkg.sv
// Shared TileLink tracker definitions: A/D opcode constants, the 2-bit
// transaction-type codes, err bit indices and small opcode helpers.
// Also provides default widths for `TL_ADDR_BITS and `TL_DATA_BYTES.
// Optional feature macro used by the tracker: TL_TRACKER_TIMEOUT_EN.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

package tl_txn_tracker_pkg;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // Completed-transaction type codes
    localparam logic [1:0] TT_GET         = 2'b00;
    localparam logic [1:0] TT_PUT_FULL    = 2'b01;
    localparam logic [1:0] TT_PUT_PARTIAL = 2'b10;

    // err bit indices
    localparam int ERR_DUP       = 0;
    localparam int ERR_UNMATCHED = 1;
    localparam int ERR_OPCODE    = 2;
    localparam int ERR_TIMEOUT   = 3;

    function automatic logic a_opcode_legal(input logic [2:0] op);
        return (op == A_GET) || (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
    endfunction

    function automatic logic [1:0] a_opcode_type(input logic [2:0] op);
        case (op)
            A_PUT_FULL:    return TT_PUT_FULL;
            A_PUT_PARTIAL: return TT_PUT_PARTIAL;
            default:       return TT_GET;
        endcase
    endfunction

    function automatic logic d_opcode_legal(input logic [2:0] op);
        return (op == D_ACCESS_ACK) || (op == D_ACCESS_ACK_DATA);
    endfunction

    // A Get must be answered with data, a Put without.
    function automatic logic d_opcode_mismatch(input logic [1:0] t, input logic [2:0] op);
        return (t == TT_GET) ? (op == D_ACCESS_ACK) : (op == D_ACCESS_ACK_DATA);
    endfunction

endpackage

// File: rtl/tl_tracker_slot.sv
// One tracker slot: valid bit, stored request record and, when
// TL_TRACKER_TIMEOUT_EN is defined, a saturating age counter that
// releases the slot once its age reaches TIMEOUT_CYCLES.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_tracker_slot
    import tl_txn_tracker_pkg::*;
`ifdef TL_TRACKER_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int AGE_BITS       = 9
)
`endif
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          alloc_i,
    input  logic [1:0]                    type_i,
    input  logic [`TL_ADDR_BITS-1:0]      addr_i,
    input  logic [`TL_DATA_BYTES*8-1:0]   data_i,
    input  logic                          retire_i,
    output logic                          valid_o,
    output logic [1:0]                    type_o,
    output logic [`TL_ADDR_BITS-1:0]      addr_o,
    output logic [`TL_DATA_BYTES*8-1:0]   data_o,
    output logic                          expire_o
);

    logic                         valid_q, valid_d;
    logic [1:0]                   type_q, type_d;
    logic [`TL_ADDR_BITS-1:0]     addr_q, addr_d;
    logic [`TL_DATA_BYTES*8-1:0]  data_q, data_d;
    logic                         expire;

`ifdef TL_TRACKER_TIMEOUT_EN
    localparam logic [AGE_BITS-1:0] AGE_MAX   = '1;
    localparam logic [AGE_BITS:0]   AGE_LIMIT = (AGE_BITS+1)'(TIMEOUT_CYCLES);

    logic [AGE_BITS-1:0] age_q, age_d;

    // Expire on the edge where the age would reach the limit, unless a D beat retires it first.
    assign expire = valid_q & ~retire_i &
                    (({1'b0, age_q} + (AGE_BITS+1)'(1)) == AGE_LIMIT);

    // Age restarts on allocation and counts up, saturating, while occupied.
    always_comb begin
        age_d = age_q;
        if (alloc_i) begin
            age_d = '0;
        end else if (valid_q && (age_q != AGE_MAX)) begin
            age_d = age_q + AGE_BITS'(1);
        end
    end

    // Age counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Release on retire/expiry; an allocation in the same cycle takes the slot again.
    always_comb begin
        valid_d = valid_q;
        type_d  = type_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (retire_i || expire) begin
            valid_d = 1'b0;
        end
        if (alloc_i) begin
            valid_d = 1'b1;
            type_d  = type_i;
            addr_d  = addr_i;
            data_d  = data_i;
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            type_q  <= TT_GET;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o  = valid_q;
    assign type_o   = type_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign expire_o = expire;

endmodule

// File: rtl/tl_txn_tracker.sv
// TileLink transaction tracker: one slot per source ID, matches A requests
// to D responses and emits one registered completion record per transaction.
// Optional macro TL_TRACKER_TIMEOUT_EN enables per-slot response timeouts (err[3]).
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_txn_tracker
    import tl_txn_tracker_pkg::*;
#(
    parameter int SOURCE_BITS    = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int AGE_BITS       = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    input  logic                          a_ready,
    input  logic [2:0]                    a_opcode,
    input  logic [SOURCE_BITS-1:0]        a_source,
    input  logic [`TL_ADDR_BITS-1:0]      a_address,
    input  logic [`TL_DATA_BYTES*8-1:0]   a_data,
    input  logic                          d_valid,
    input  logic                          d_ready,
    input  logic [2:0]                    d_opcode,
    input  logic [SOURCE_BITS-1:0]        d_source,
    input  logic [`TL_DATA_BYTES*8-1:0]   d_data,
    output logic                          transaction_done,
    output logic [1:0]                    transaction_type,
    output logic [`TL_ADDR_BITS-1:0]      address,
    output logic [`TL_DATA_BYTES*8-1:0]   write_data,
    output logic [`TL_DATA_BYTES*8-1:0]   read_data,
    output logic [SOURCE_BITS:0]          outstanding,
    output logic [3:0]                    err
);

    localparam int SLOTS = 1 << SOURCE_BITS;
    localparam int AW    = `TL_ADDR_BITS;
    localparam int DW    = `TL_DATA_BYTES * 8;

    logic             a_fire, d_fire, a_legal, d_hit, a_dup, a_take;
    logic [1:0]       a_type;
    logic [DW-1:0]    a_store_data;
    logic [SLOTS-1:0] slot_vld, slot_alloc, slot_retire, slot_expire;
    logic [1:0]       slot_type [SLOTS];
    logic [AW-1:0]    slot_addr [SLOTS];
    logic [DW-1:0]    slot_data [SLOTS];
    logic [SOURCE_BITS:0] n_free;

    logic                 done_q, done_d;
    logic [1:0]           type_q, type_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [SOURCE_BITS:0] outstanding_q, outstanding_d;
    logic [3:0]           err_q, err_d;

    assign a_fire       = a_valid & a_ready;
    assign d_fire       = d_valid & d_ready;
    assign a_legal      = a_opcode_legal(a_opcode);
    assign a_type       = a_opcode_type(a_opcode);
    assign a_store_data = (a_type == TT_GET) ? '0 : a_data;
    assign d_hit        = d_fire & slot_vld[d_source];

    // A target slot is free if empty, or if it is being released this same cycle.
    assign a_dup  = a_fire & a_legal & slot_vld[a_source] &
                    ~(d_hit & (d_source == a_source)) & ~slot_expire[a_source];
    assign a_take = a_fire & a_legal & ~a_dup;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign slot_alloc[i]  = a_take & (a_source == SOURCE_BITS'(i));
        assign slot_retire[i] = d_hit & (d_source == SOURCE_BITS'(i));

        tl_tracker_slot
`ifdef TL_TRACKER_TIMEOUT_EN
        #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .AGE_BITS       (AGE_BITS)
        )
`endif
        u_slot (
            .clk_i    (clk),
            .rst_i    (rst),
            .alloc_i  (slot_alloc[i]),
            .type_i   (a_type),
            .addr_i   (a_address),
            .data_i   (a_store_data),
            .retire_i (slot_retire[i]),
            .valid_o  (slot_vld[i]),
            .type_o   (slot_type[i]),
            .addr_o   (slot_addr[i]),
            .data_o   (slot_data[i]),
            .expire_o (slot_expire[i])
        );
    end

    // Number of slots released this cycle by D retire or timeout.
    always_comb begin
        n_free = '0;
        for (int i = 0; i < SLOTS; i++) begin
            n_free = n_free + {{SOURCE_BITS{1'b0}}, slot_retire[i] | slot_expire[i]};
        end
    end

    // Completion record, error pulses and occupancy for the next cycle.
    always_comb begin
        done_d  = d_hit;
        type_d  = TT_GET;
        addr_d  = '0;
        wdata_d = '0;
        rdata_d = '0;
        if (d_hit) begin
            type_d  = slot_type[d_source];
            addr_d  = slot_addr[d_source];
            wdata_d = slot_data[d_source];
            rdata_d = (d_opcode == D_ACCESS_ACK_DATA) ? d_data : '0;
        end
        err_d = '0;
        err_d[ERR_DUP]       = a_dup;
        err_d[ERR_UNMATCHED] = d_fire & ~slot_vld[d_source];
        err_d[ERR_OPCODE]    = (a_fire & ~a_legal) |
                               (d_fire & ~d_opcode_legal(d_opcode)) |
                               (d_hit & d_opcode_mismatch(slot_type[d_source], d_opcode));
`ifdef TL_TRACKER_TIMEOUT_EN
        err_d[ERR_TIMEOUT]   = |slot_expire;
`else
        err_d[ERR_TIMEOUT]   = 1'b0;
`endif
        outstanding_d = outstanding_q + {{SOURCE_BITS{1'b0}}, a_take} - n_free;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q        <= 1'b0;
            type_q        <= TT_GET;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            outstanding_q <= '0;
            err_q         <= '0;
        end else begin
            done_q        <= done_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign transaction_done = done_q;
    assign transaction_type = type_q;
    assign address          = addr_q;
    assign write_data       = wdata_q;
    assign read_data        = rdata_q;
    assign outstanding      = outstanding_q;
    assign err              = err_q;

endmodule

// File: tb/tb_tl_txn_tracker.sv
// Directed bench for tl_txn_tracker with a transaction-level reference model.
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tb_tl_txn_tracker;

    localparam int SB = 2;
    localparam int NS = 4;
    localparam int AW = `TL_ADDR_BITS;
    localparam int DW = `TL_DATA_BYTES * 8;
    localparam int TO = 16;

    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid, a_ready, d_valid, d_ready;
    logic [2:0]    a_opcode, d_opcode;
    logic [SB-1:0] a_source, d_source;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_data, d_data;
    logic          transaction_done;
    logic [1:0]    transaction_type;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data, read_data;
    logic [SB:0]   outstanding;
    logic [3:0]    err;

    tl_txn_tracker #(
        .SOURCE_BITS    (SB),
        .TIMEOUT_CYCLES (TO),
        .AGE_BITS       (9)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_opcode         (a_opcode),
        .a_source         (a_source),
        .a_address        (a_address),
        .a_data           (a_data),
        .d_valid          (d_valid),
        .d_ready          (d_ready),
        .d_opcode         (d_opcode),
        .d_source         (d_source),
        .d_data           (d_data),
        .transaction_done (transaction_done),
        .transaction_type (transaction_type),
        .address          (address),
        .write_data       (write_data),
        .read_data        (read_data),
        .outstanding      (outstanding),
        .err              (err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: one entry per source ID
    bit            m_vld   [NS];
    logic [1:0]    m_type  [NS];
    logic [AW-1:0] m_addr  [NS];
    logic [DW-1:0] m_wdata [NS];
    int            m_age   [NS];

    logic          exp_done  = 1'b0;
    logic [1:0]    exp_type  = '0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic [3:0]    exp_err   = '0;
    int            exp_out   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_vld[s] = 1'b0; m_type[s] = '0; m_addr[s] = '0; m_wdata[s] = '0; m_age[s] = 0;
        end
        exp_done = 1'b0; exp_type = '0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        exp_err = '0; exp_out = 0;
    endtask

    task automatic model_alloc(input int src, input logic [1:0] t, input logic [DW-1:0] wd);
        if (m_vld[src]) begin
            exp_err[0] = 1'b1;
        end else begin
            m_vld[src] = 1'b1; m_type[src] = t; m_addr[src] = a_address;
            m_wdata[src] = wd; m_age[src] = 0;
        end
    endtask

    // What the tracker must present after the clock edge that sees the current inputs.
    task automatic model_step();
        int cnt;
        exp_done = 1'b0; exp_type = '0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        exp_err = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (d_valid && d_ready) begin
            if (d_opcode != OP_ACK && d_opcode != OP_ACKD) exp_err[2] = 1'b1;
            if (m_vld[d_source]) begin
                exp_done  = 1'b1;
                exp_type  = m_type[d_source];
                exp_addr  = m_addr[d_source];
                exp_wdata = m_wdata[d_source];
                exp_rdata = (d_opcode == OP_ACKD) ? d_data : '0;
                if (m_type[d_source] == 2'b00 && d_opcode == OP_ACK)  exp_err[2] = 1'b1;
                if (m_type[d_source] != 2'b00 && d_opcode == OP_ACKD) exp_err[2] = 1'b1;
                m_vld[d_source] = 1'b0;
            end else begin
                exp_err[1] = 1'b1;
            end
        end
`ifdef TL_TRACKER_TIMEOUT_EN
        for (int s = 0; s < NS; s++) begin
            if (m_vld[s]) begin
                m_age[s]++;
                if (m_age[s] == TO) begin
                    m_vld[s] = 1'b0;
                    exp_err[3] = 1'b1;
                end
            end
        end
`endif
        if (a_valid && a_ready) begin
            case (a_opcode)
                OP_GET:  model_alloc(int'(a_source), 2'b00, '0);
                OP_PUTF: model_alloc(int'(a_source), 2'b01, a_data);
                OP_PUTP: model_alloc(int'(a_source), 2'b10, a_data);
                default: exp_err[2] = 1'b1;
            endcase
        end
        cnt = 0;
        for (int s = 0; s < NS; s++) if (m_vld[s]) cnt++;
        exp_out = cnt;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("done", {63'd0, transaction_done}, {63'd0, exp_done});
        check("err", {60'd0, err}, {60'd0, exp_err});
        check("outstanding", {61'd0, outstanding}, 64'(exp_out));
        if (exp_done) begin
            check("rec_type", {62'd0, transaction_type}, {62'd0, exp_type});
            check("rec_addr", {32'd0, address}, {32'd0, exp_addr});
            check("rec_wdata", write_data, exp_wdata);
            check("rec_rdata", read_data, exp_rdata);
        end
    end

    task automatic step(input bit av, input bit ar, input logic [2:0] aop, input int asrc,
                        input logic [AW-1:0] aad, input logic [DW-1:0] adt,
                        input bit dv, input logic [2:0] dop, input int dsrc,
                        input logic [DW-1:0] ddt);
        a_valid = av; a_ready = ar; a_opcode = aop; a_source = SB'(asrc);
        a_address = aad; a_data = adt;
        d_valid = dv; d_ready = 1'b1; d_opcode = dop; d_source = SB'(dsrc); d_data = ddt;
        @(posedge clk);
        model_step();
        #1;
        a_valid = 1'b0; d_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, OP_GET, 0, '0, '0, 1'b0, OP_ACK, 0, '0);
    endtask

    task automatic a_only(input logic [2:0] op, input int src, input logic [AW-1:0] ad,
                          input logic [DW-1:0] dt);
        step(1'b1, 1'b1, op, src, ad, dt, 1'b0, OP_ACK, 0, '0);
    endtask

    task automatic d_only(input logic [2:0] op, input int src, input logic [DW-1:0] dt);
        step(1'b0, 1'b1, OP_GET, 0, '0, '0, 1'b1, op, src, dt);
    endtask

    initial begin
        a_valid = 1'b0; a_ready = 1'b1; a_opcode = '0; a_source = '0; a_address = '0; a_data = '0;
        d_valid = 1'b0; d_ready = 1'b1; d_opcode = '0; d_source = '0; d_data = '0;
        model_reset();
        #1 rst = 1'b1;

        // Fires during reset are ignored
        a_only(OP_GET, 1, 32'h44, '0);
        d_only(OP_ACKD, 1, 64'h1);
        check("rst_done", {63'd0, transaction_done}, 64'd0);
        check("rst_type", {62'd0, transaction_type}, 64'd0);
        check("rst_addr", {32'd0, address}, 64'd0);
        check("rst_wdata", write_data, 64'd0);
        check("rst_rdata", read_data, 64'd0);
        check("rst_out", {61'd0, outstanding}, 64'd0);
        check("rst_err", {60'd0, err}, 64'd0);
        rst = 1'b0;
        idle();
        check("post_rst_out", {61'd0, outstanding}, 64'd0);

        // Get + AccessAckData
        a_only(OP_GET, 0, 32'h40, 64'hDEAD);
        check("get_out1", {61'd0, outstanding}, 64'd1);
        check("get_nodone", {63'd0, transaction_done}, 64'd0);
        d_only(OP_ACKD, 0, 64'hAA00000000000008);
        check("get_done", {63'd0, transaction_done}, 64'd1);
        check("get_type", {62'd0, transaction_type}, 64'd0);
        check("get_addr", {32'd0, address}, 64'h40);
        check("get_wdata", write_data, 64'd0);
        check("get_rdata", read_data, 64'hAA00000000000008);
        check("get_out0", {61'd0, outstanding}, 64'd0);
        idle();
        check("get_pulse", {63'd0, transaction_done}, 64'd0);

        // PutFull + AccessAck
        a_only(OP_PUTF, 1, 32'h80, 64'h1234);
        d_only(OP_ACK, 1, 64'hFFFF);
        check("put_done", {63'd0, transaction_done}, 64'd1);
        check("put_type", {62'd0, transaction_type}, 64'd1);
        check("put_wdata", write_data, 64'h1234);
        check("put_rdata", read_data, 64'd0);
        check("put_err", {60'd0, err}, 64'd0);

        // Duplicate source
        a_only(OP_GET, 2, 32'h100, '0);
        a_only(OP_GET, 2, 32'h200, '0);
        check("dup_err", {60'd0, err}, 64'h1);
        check("dup_out", {61'd0, outstanding}, 64'd1);
        d_only(OP_ACKD, 2, 64'h5);
        check("dup_keep_addr", {32'd0, address}, 64'h100);

        // Unmatched D
        d_only(OP_ACK, 3, '0);
        check("unm_err", {60'd0, err}, 64'h2);
        check("unm_done", {63'd0, transaction_done}, 64'd0);

        // Same-cycle retire and allocate on src0
        a_only(OP_GET, 0, 32'h10, '0);
        step(1'b1, 1'b1, OP_PUTP, 0, 32'h20, 64'h55, 1'b1, OP_ACKD, 0, 64'h77);
        check("same_done", {63'd0, transaction_done}, 64'd1);
        check("same_addr", {32'd0, address}, 64'h10);
        check("same_rdata", read_data, 64'h77);
        check("same_out", {61'd0, outstanding}, 64'd1);
        check("same_err", {60'd0, err}, 64'd0);
        d_only(OP_ACK, 0, '0);
        check("new_type", {62'd0, transaction_type}, 64'd2);
        check("new_addr", {32'd0, address}, 64'h20);
        check("new_wdata", write_data, 64'h55);

        // Illegal A opcode
        a_only(3'd2, 1, 32'h300, 64'h1);
        check("bada_err", {60'd0, err}, 64'h4);
        check("bada_out", {61'd0, outstanding}, 64'd0);

        // Mismatched response opcodes
        a_only(OP_GET, 1, 32'h8, '0);
        d_only(OP_ACK, 1, '0);
        check("mis_get_done", {63'd0, transaction_done}, 64'd1);
        check("mis_get_err", {60'd0, err}, 64'h4);
        a_only(OP_PUTF, 1, 32'hC, 64'h9);
        d_only(OP_ACKD, 1, 64'h33);
        check("mis_put_err", {60'd0, err}, 64'h4);
        check("mis_put_rdata", read_data, 64'h33);

        // No handshake without a_ready
        step(1'b1, 1'b0, OP_GET, 2, 32'h4, '0, 1'b0, OP_ACK, 0, '0);
        check("noready_out", {61'd0, outstanding}, 64'd0);

        // Fill every slot, then drain
        for (int s = 0; s < NS; s++) a_only(OP_PUTF, s, AW'(32'h1000 + s), DW'(s + 1));
        check("full_out", {61'd0, outstanding}, 64'd4);
        for (int s = 0; s < NS; s++) d_only(OP_ACK, s, '0);
        check("drain_out", {61'd0, outstanding}, 64'd0);

        // Reset mid-transaction forgets in-flight requests
        a_only(OP_GET, 3, 32'h700, '0);
        check("mid_out1", {61'd0, outstanding}, 64'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_async_out", {61'd0, outstanding}, 64'd0);
        a_only(OP_GET, 2, 32'h710, '0);
        rst = 1'b0;
        d_only(OP_ACK, 3, '0);
        check("mid_err", {60'd0, err}, 64'h2);
        check("mid_done", {63'd0, transaction_done}, 64'd0);
        d_only(OP_ACKD, 2, 64'h1);
        check("mid_ign_err", {60'd0, err}, 64'h2);

`ifdef TL_TRACKER_TIMEOUT_EN
        // Timeout after TO cycles
        a_only(OP_GET, 1, 32'h900, '0);
        repeat (TO - 1) idle();
        check("to_pre_err", {60'd0, err}, 64'd0);
        check("to_pre_out", {61'd0, outstanding}, 64'd1);
        idle();
        check("to_err", {60'd0, err}, 64'h8);
        check("to_out", {61'd0, outstanding}, 64'd0);
        check("to_nodone", {63'd0, transaction_done}, 64'd0);
`else
        // Without timeouts an unanswered request stays outstanding
        a_only(OP_GET, 1, 32'h900, '0);
        repeat (TO + 4) idle();
        check("nto_err", {60'd0, err}, 64'd0);
        check("nto_out", {61'd0, outstanding}, 64'd1);
        d_only(OP_ACKD, 1, 64'h2);
        check("nto_done", {63'd0, transaction_done}, 64'd1);
`endif
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
